// File: rtl/definitions_pkg.sv
// rtl/definitions_pkg.sv - shared clock/baud defaults, UART tx types and bit divider helper
package definitions_pkg;

  localparam int CLOCK_RATE = 50_000_000;
  localparam int BAUD_RATE  = 115_200;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD} parity_mode_t;

  // Clocks per bit, rounded to nearest.
  function automatic int bit_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - clock-enable divider producing one tick every DIV clocks
module baud_tick_gen #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  // Tick on the last count of the period; held off while clear is asserted.
  assign tick = !clear && (r_cnt == CW'(DIV - 1));

  // Count up, wrapping to 0 on the tick edge; clear pins the phase at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - parametrised UART transmitter: start, data LSB first, parity, 1/2 stop
module uart_tx_frame
  import definitions_pkg::*;
#(
  parameter int CLK_HZ    = CLOCK_RATE,
  parameter int BAUD      = BAUD_RATE,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic                 tx_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 tx_out
);

  localparam int BIT_DIV = bit_div(CLK_HZ, BAUD);
  localparam int IDX_W   = $clog2(DATA_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be in 5..9");
  end
  if (BIT_DIV < 2) begin : g_bad_bit_div
    $error("uart_tx_frame: BIT_DIV must be at least 2");
  end

  tx_state_t              r_state;
  logic [DATA_BITS-1:0]   r_shift;
  logic [IDX_W-1:0]       r_bit_idx;
  logic                   r_par_en;
  logic                   r_par_bit;
  logic                   r_two_stop;
  logic                   r_stop_second;
  logic                   r_tx_out;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_tick;
  logic                   w_clear;
  logic                   w_accept;
  parity_mode_t           w_pmode;

  assign w_pmode  = parity_mode_t'(parity_mode);
  assign tx_ready = (r_state == TX_IDLE) && enable && !rst;
  assign w_accept = tx_valid && tx_ready;
  // Divider only runs while a frame is on the line.
  assign w_clear  = (r_state == TX_IDLE) || !enable;

  assign tx_out = r_tx_out;
  assign busy   = r_busy;
  assign done   = r_done;

  baud_tick_gen #(.DIV(BIT_DIV)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (w_clear),
    .tick  (w_tick)
  );

  // Frame sequencer with registered line, busy and done outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= TX_IDLE;
      r_shift       <= '0;
      r_bit_idx     <= '0;
      r_par_en      <= 1'b0;
      r_par_bit     <= 1'b0;
      r_two_stop    <= 1'b0;
      r_stop_second <= 1'b0;
      r_tx_out      <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else if (!enable) begin
      // Abort: drop the frame silently, line back to idle.
      r_state   <= TX_IDLE;
      r_bit_idx <= '0;
      r_tx_out  <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        TX_IDLE: begin
          if (w_accept) begin
            // Parity is resolved at accept time from the same word being latched.
            r_shift       <= tx_data;
            r_par_en      <= (w_pmode == PAR_EVEN) || (w_pmode == PAR_ODD);
            r_par_bit     <= (^tx_data) ^ (w_pmode == PAR_ODD);
            r_two_stop    <= two_stop;
            r_stop_second <= 1'b0;
            r_bit_idx     <= '0;
            r_state       <= TX_START;
            r_tx_out      <= 1'b0;
            r_busy        <= 1'b1;
          end
        end
        TX_START: begin
          if (w_tick) begin
            r_state  <= TX_DATA;
            r_tx_out <= r_shift[0];
          end
        end
        TX_DATA: begin
          if (w_tick) begin
            if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
              r_bit_idx <= '0;
              if (r_par_en) begin
                r_state  <= TX_PARITY;
                r_tx_out <= r_par_bit;
              end else begin
                r_state  <= TX_STOP;
                r_tx_out <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= r_shift >> 1;
              r_tx_out  <= r_shift[1];
            end
          end
        end
        TX_PARITY: begin
          if (w_tick) begin
            r_state  <= TX_STOP;
            r_tx_out <= 1'b1;
          end
        end
        TX_STOP: begin
          if (w_tick) begin
            if (r_two_stop && !r_stop_second) begin
              r_stop_second <= 1'b1;
            end else begin
              r_state <= TX_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state  <= TX_IDLE;
          r_tx_out <= 1'b1;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - scoreboard bench for uart_tx_frame at 16 clocks per bit
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;

  logic       tx_valid8, tx_ready8, busy8, done8, tx_out8, two_stop8;
  logic [7:0] tx_data8;
  logic [1:0] parity_mode8;

  logic       tx_valid7, tx_ready7, busy7, done7, tx_out7, two_stop7;
  logic [6:0] tx_data7;
  logic [1:0] parity_mode7;

  logic       sel;
  logic       m_tx_out, m_busy, m_done, m_ready;

  int         errors = 0;
  int         checks = 0;
  logic       bit_q[$];
  int         len_q[$];
  logic       seen_done;

  always #5 clk = ~clk;

  uart_tx_frame #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8)) dut8 (
    .clk(clk), .rst(rst), .enable(enable), .tx_valid(tx_valid8), .tx_data(tx_data8),
    .parity_mode(parity_mode8), .two_stop(two_stop8), .tx_ready(tx_ready8),
    .busy(busy8), .done(done8), .tx_out(tx_out8)
  );

  uart_tx_frame #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(7)) dut7 (
    .clk(clk), .rst(rst), .enable(enable), .tx_valid(tx_valid7), .tx_data(tx_data7),
    .parity_mode(parity_mode7), .two_stop(two_stop7), .tx_ready(tx_ready7),
    .busy(busy7), .done(done7), .tx_out(tx_out7)
  );

  assign m_tx_out = sel ? tx_out7   : tx_out8;
  assign m_busy   = sel ? busy7     : busy8;
  assign m_done   = sel ? done7     : done8;
  assign m_ready  = sel ? tx_ready7 : tx_ready8;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a word to the selected transmitter and push its expected line bits.
  task automatic start_frame(input logic [8:0] d, input logic [1:0] pm, input logic ts, input int nb);
    logic p;
    int   n;
    p = 1'b0;
    for (int i = 0; i < nb; i++) p = p ^ d[i];
    if (pm == 2'b10) p = ~p;
    bit_q.push_back(1'b0);
    n = 1;
    for (int i = 0; i < nb; i++) begin
      bit_q.push_back(d[i]);
      n++;
    end
    if (pm == 2'b01 || pm == 2'b10) begin
      bit_q.push_back(p);
      n++;
    end
    bit_q.push_back(1'b1);
    n++;
    if (ts) begin
      bit_q.push_back(1'b1);
      n++;
    end
    len_q.push_back(n * 16);
    if (sel) begin
      tx_valid7 = 1'b1; tx_data7 = d[6:0]; parity_mode7 = pm; two_stop7 = ts;
    end else begin
      tx_valid8 = 1'b1; tx_data8 = d[7:0]; parity_mode8 = pm; two_stop8 = ts;
    end
  endtask

  // Called in the START cycle; samples each bit mid-period until done.
  task automatic watch_frame(input string tag);
    int   len, nbits, popped, c;
    logic eb;
    len    = len_q.pop_front();
    nbits  = len / 16;
    popped = 0;
    c      = 0;
    while (!m_done && c < len + 40) begin
      if (c % 16 == 8 && popped < nbits) begin
        eb = bit_q.pop_front();
        popped++;
        check({tag, "_bit"}, {31'd0, m_tx_out}, {31'd0, eb});
        check({tag, "_busy"}, {31'd0, m_busy}, 32'd1);
        check({tag, "_ready"}, {31'd0, m_ready}, 32'd0);
      end
      @(posedge clk); #1;
      c++;
    end
    while (popped < nbits) begin
      eb = bit_q.pop_front();
      popped++;
    end
    check({tag, "_len"}, c, len);
    check({tag, "_done"}, {31'd0, m_done}, 32'd1);
    check({tag, "_done_busy"}, {31'd0, m_busy}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0;
    rst = 1'b1; enable = 1'b1;
    tx_valid8 = 1'b0; tx_data8 = '0; parity_mode8 = '0; two_stop8 = 1'b0;
    tx_valid7 = 1'b0; tx_data7 = '0; parity_mode7 = '0; two_stop7 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_out", {31'd0, tx_out8}, 32'd1);
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_done", {31'd0, done8}, 32'd0);
    check("rst_ready", {31'd0, tx_ready8}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", {31'd0, tx_ready8}, 32'd1);

    // 1: 0x55, no parity, one stop.
    start_frame(9'h055, 2'b00, 1'b0, 8);
    @(posedge clk); #1;
    tx_valid8 = 1'b0;
    watch_frame("t1");

    // 2: 0xA5 even parity two stop, then odd parity.
    start_frame(9'h0A5, 2'b01, 1'b1, 8);
    @(posedge clk); #1;
    tx_valid8 = 1'b0;
    watch_frame("t2even");
    start_frame(9'h0A5, 2'b10, 1'b1, 8);
    @(posedge clk); #1;
    tx_valid8 = 1'b0;
    watch_frame("t2odd");

    // 3: back-to-back with tx_valid held high.
    start_frame(9'h001, 2'b00, 1'b0, 8);
    @(posedge clk); #1;
    start_frame(9'h080, 2'b00, 1'b0, 8);
    watch_frame("t3a");
    check("t3_gap_line", {31'd0, tx_out8}, 32'd1);
    check("t3_gap_ready", {31'd0, tx_ready8}, 32'd1);
    @(posedge clk); #1;
    tx_valid8 = 1'b0;
    check("t3_next_start", {31'd0, tx_out8}, 32'd0);
    check("t3_next_busy", {31'd0, busy8}, 32'd1);
    watch_frame("t3b");

    // 4: abort by enable during data bit 3 of 0xFF.
    tx_data8 = 8'hFF; parity_mode8 = 2'b00; two_stop8 = 1'b0; tx_valid8 = 1'b1;
    @(posedge clk); #1;
    tx_valid8 = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    check("t4_pre_busy", {31'd0, busy8}, 32'd1);
    enable = 1'b0;
    @(posedge clk); #1;
    check("t4_tx_out", {31'd0, tx_out8}, 32'd1);
    check("t4_busy", {31'd0, busy8}, 32'd0);
    check("t4_ready", {31'd0, tx_ready8}, 32'd0);
    seen_done = done8;
    repeat (20) begin
      @(posedge clk); #1;
      seen_done = seen_done | done8 | busy8;
    end
    check("t4_no_done", {31'd0, seen_done}, 32'd0);
    enable = 1'b1;
    start_frame(9'h000, 2'b00, 1'b0, 8);
    @(posedge clk); #1;
    tx_valid8 = 1'b0;
    watch_frame("t4clean");

    // 5: asynchronous reset in the stop bit.
    tx_data8 = 8'h55; parity_mode8 = 2'b00; two_stop8 = 1'b0; tx_valid8 = 1'b1;
    @(posedge clk); #1;
    tx_valid8 = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    check("t5_pre_busy", {31'd0, busy8}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_tx_out", {31'd0, tx_out8}, 32'd1);
    check("t5_async_busy", {31'd0, busy8}, 32'd0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    check("t5_ready", {31'd0, tx_ready8}, 32'd1);
    check("t5_busy", {31'd0, busy8}, 32'd0);
    check("t5_done", {31'd0, done8}, 32'd0);

    // 6: seven data bits, odd parity.
    sel = 1'b1;
    start_frame(9'h07F, 2'b10, 1'b0, 7);
    @(posedge clk); #1;
    tx_valid7 = 1'b0;
    watch_frame("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
